cache_mem_ctrl: RTL and testbench
=================================

Name: cache_mem_ctrl

Overview:
Direct-mapped, write-back, write-allocate cache controller. It acts as the initiator on the cache↔BRAM latency-model handshake. It takes single-word CPU load/store requests and serves hits from internal storage. On a miss it issues one-cycle cache_ram_valid requests to the BRAM model, writing back a dirty victim first and then filling, and waits for the bram_valid completion pulse. It sits between the lab2 CPU core and the BRAM latency model.

Parameters:
ADDR_W, 32, CPU/memory byte-address width
DATA_W, 32, word width; one word per cache line
INDEX_W, 4, line-index bits (2**INDEX_W lines = 16)

Ports:
cpu_clk  in  1  clock
rst  in  1  reset
cpu_req  in  1  CPU request valid; held with addr/we/wdata stable until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cache_ram_valid  out  1  one-cycle request pulse to BRAM
ram_we  out  1  1=write-back, 0=fill read; valid with cache_ram_valid, held until bram_valid
ram_addr  out  ADDR_W  word-aligned memory address, held until bram_valid
ram_wdata  out  DATA_W  victim data for write-back, held until bram_valid
bram_valid  in  1  one-cycle BRAM completion pulse
ram_rdata  in  DATA_W  fill data, sampled on the cycle bram_valid=1

Behaviour:
- Reset rst, asynchronous, active-high; clock cpu_clk. On reset: state=IDLE; all valid and dirty bits cleared; cpu_ready=0, cache_ram_valid=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rdata=0. Reset mid-miss abandons the transaction. No write-back occurs, and dirty data is lost by design.
- Address split: index=cpu_addr[INDEX_W+1:2]; tag=cpu_addr[ADDR_W-1:INDEX_W+2]. Hit = valid[index] and tag match, evaluated combinationally in IDLE.
- All outputs are registered.
- States: IDLE, WB, FILL, RESP.
- IDLE, no cpu_req: stay.
- IDLE, cpu_req and hit: a load latches data into cpu_rdata; a store writes cpu_wdata and sets dirty. Go to RESP.
- IDLE, cpu_req, miss, victim clean or invalid: cache_ram_valid=1 for one cycle, ram_we=0, ram_addr={cpu tag,index,2'b00}. Go to FILL.
- IDLE, cpu_req, miss, victim valid and dirty: cache_ram_valid=1, ram_we=1, ram_addr={victim tag,index,2'b00}, ram_wdata=victim data. Go to WB.
- WB: wait for bram_valid. On bram_valid, pulse cache_ram_valid with ram_we=0 and the CPU fill address, then go to FILL.
- FILL: wait for bram_valid. On bram_valid, write the line: tag, valid=1, data=(cpu_we ? cpu_wdata : ram_rdata), dirty=cpu_we. cpu_rdata=ram_rdata for loads. Go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then go to IDLE. A request still asserted on the following cycle is treated as a new request.
- cache_ram_valid is never high for two consecutive cycles. It is never reasserted before bram_valid returns, which the BRAM model requires to avoid restarting its counter.
- With the 8-count BRAM model, bram_valid arrives 9 cycles after the cache_ram_valid cycle.
- Latencies with the request first seen in cycle T:
  - hit: cpu_ready in T+1
  - clean miss: cache_ram_valid in T+1, bram_valid in T+10, cpu_ready in T+11
  - dirty miss: write-back pulse in T+1, fill pulse in T+11, cpu_ready in T+21
- bram_valid in IDLE or RESP is ignored. Changes on cpu_* while in WB, FILL or RESP are a protocol violation; the controller uses the live cpu_* values.

Decomposition:
- Shared package cache_pkg: state encoding (IDLE=2'd0, WB=2'd1, FILL=2'd2, RESP=2'd3), ADDR_W/DATA_W/INDEX_W defaults, and a TAG_W=ADDR_W-INDEX_W-2 derivation.
- One sub-module, cache_line_array: valid, dirty, tag and data storage. It has a combinational read port and a single synchronous write port, and clears valid/dirty on rst.

Test Plan:
- After reset, load 0x0000_0040 → cache_ram_valid in T+1 with ram_we=0, ram_addr=0x40; bram_valid in T+10 with ram_rdata=0xDEAD_BEEF → cpu_ready in T+11, cpu_rdata=0xDEAD_BEEF.
- Repeat the load of 0x40 → hit, cpu_ready in T+1, cpu_rdata=0xDEAD_BEEF, no cache_ram_valid.
- Store 0x1234_5678 to 0x40 (hit) → cpu_ready in T+1. Then load 0x0000_0440 (same index, new tag) → write-back pulse with ram_we=1, ram_addr=0x40, ram_wdata=0x1234_5678; fill pulse with ram_we=0, ram_addr=0x440 in T+11; cpu_ready in T+21.
- Store miss to 0x80 with cpu_wdata=0xA5A5_A5A5 → fill, then cpu_ready. A following load of 0x80 hits and returns 0xA5A5_A5A5 even though ram_rdata was 0.
- Assert rst in cycle T+5 of a clean miss → all outputs 0 and state IDLE. A load of 0x40 afterwards misses, confirming valid was cleared.
- Across all scenarios, check that cache_ram_valid is never high on consecutive cycles and that a spurious bram_valid in IDLE causes no state change.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller:
// default geometry and the controller state encoding.
package cache_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned INDEX_W = 4;
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Per-line valid/dirty/tag/data storage: combinational read port, one
// synchronous write port; only valid and dirty are cleared by reset.
module cache_line_array #(
    parameter int unsigned INDEX_W = cache_pkg::INDEX_W,
    parameter int unsigned TAG_W   = cache_pkg::TAG_W,
    parameter int unsigned DATA_W  = cache_pkg::DATA_W
) (
    input  logic               cpu_clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid_c,
    output logic               rd_dirty_c,
    output logic [TAG_W-1:0]   rd_tag_c,
    output logic [DATA_W-1:0]  rd_data_c,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_dirty
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_bits;
    logic [LINES-1:0]  dirty_bits;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    assign rd_valid_c = valid_bits[rd_index];
    assign rd_dirty_c = dirty_bits[rd_index];
    assign rd_tag_c   = tag_mem[rd_index];
    assign rd_data_c  = data_mem[rd_index];

    // Line state bits: reset drops every line, dirty contents included.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_index] <= 1'b1;
            dirty_bits[wr_index] <= wr_dirty;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller; initiator on
// the cache-to-BRAM request/completion handshake.
module cache_mem_ctrl #(
    parameter int unsigned ADDR_W  = cache_pkg::ADDR_W,
    parameter int unsigned DATA_W  = cache_pkg::DATA_W,
    parameter int unsigned INDEX_W = cache_pkg::INDEX_W
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cache_ram_valid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              bram_valid,
    input  logic [DATA_W-1:0] ram_rdata
);

    import cache_pkg::*;

    localparam int unsigned LTAG_W = ADDR_W - INDEX_W - 2;

    state_t state;
    state_t state_n;

    logic [INDEX_W-1:0] index;
    logic [LTAG_W-1:0]  tag;
    logic               addr_lsb_unused;

    logic               line_valid_c;
    logic               line_dirty_c;
    logic [LTAG_W-1:0]  line_tag_c;
    logic [DATA_W-1:0]  line_data_c;
    logic               hit_c;
    logic [ADDR_W-1:0]  fill_addr_c;
    logic [ADDR_W-1:0]  victim_addr_c;

    logic               wr_en_c;
    logic [DATA_W-1:0]  wr_data_c;
    logic               wr_dirty_c;

    logic               cpu_ready_n;
    logic               ram_valid_n;
    logic               ram_we_n;
    logic [ADDR_W-1:0]  ram_addr_n;
    logic [DATA_W-1:0]  ram_wdata_n;
    logic [DATA_W-1:0]  cpu_rdata_n;

    assign index           = cpu_addr[INDEX_W+1:2];
    assign tag             = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign hit_c         = line_valid_c && (line_tag_c == tag);
    assign fill_addr_c   = {tag, index, 2'b00};
    assign victim_addr_c = {line_tag_c, index, 2'b00};

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (LTAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .rd_index   (index),
        .rd_valid_c (line_valid_c),
        .rd_dirty_c (line_dirty_c),
        .rd_tag_c   (line_tag_c),
        .rd_data_c  (line_data_c),
        .wr_en      (wr_en_c),
        .wr_index   (index),
        .wr_tag     (tag),
        .wr_data    (wr_data_c),
        .wr_dirty   (wr_dirty_c)
    );

    // State register and registered outputs.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cpu_ready       <= 1'b0;
            cache_ram_valid <= 1'b0;
            ram_we          <= 1'b0;
            ram_addr        <= '0;
            ram_wdata       <= '0;
            cpu_rdata       <= '0;
        end else begin
            state           <= state_n;
            cpu_ready       <= cpu_ready_n;
            cache_ram_valid <= ram_valid_n;
            ram_we          <= ram_we_n;
            ram_addr        <= ram_addr_n;
            ram_wdata       <= ram_wdata_n;
            cpu_rdata       <= cpu_rdata_n;
        end
    end

    // Next state, next outputs and line writes; BRAM request fields hold
    // their value until the next request is launched.
    always_comb begin
        state_n     = state;
        cpu_ready_n = 1'b0;
        ram_valid_n = 1'b0;
        ram_we_n    = ram_we;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        cpu_rdata_n = cpu_rdata;
        wr_en_c     = 1'b0;
        wr_data_c   = cpu_wdata;
        wr_dirty_c  = 1'b1;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (hit_c) begin
                        wr_en_c     = cpu_we;
                        cpu_ready_n = 1'b1;
                        state_n     = RESP;
                        if (!cpu_we) begin
                            cpu_rdata_n = line_data_c;
                        end
                    end else begin
                        ram_valid_n = 1'b1;
                        if (line_valid_c && line_dirty_c) begin
                            ram_we_n    = 1'b1;
                            ram_addr_n  = victim_addr_c;
                            ram_wdata_n = line_data_c;
                            state_n     = WB;
                        end else begin
                            ram_we_n    = 1'b0;
                            ram_addr_n  = fill_addr_c;
                            state_n     = FILL;
                        end
                    end
                end
            end
            WB: begin
                if (bram_valid) begin
                    ram_valid_n = 1'b1;
                    ram_we_n    = 1'b0;
                    ram_addr_n  = fill_addr_c;
                    state_n     = FILL;
                end
            end
            FILL: begin
                if (bram_valid) begin
                    // Store misses allocate the line with the CPU data, already dirty.
                    wr_en_c     = 1'b1;
                    wr_data_c   = cpu_we ? cpu_wdata : ram_rdata;
                    wr_dirty_c  = cpu_we;
                    cpu_ready_n = 1'b1;
                    state_n     = RESP;
                    if (!cpu_we) begin
                        cpu_rdata_n = ram_rdata;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: flat-memory reference model plus
// line-residency tracking for expected latencies and BRAM traffic.
module tb_cache_mem_ctrl;

    import cache_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cache_ram_valid;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        bram_valid;
    logic [31:0] ram_rdata;

    logic        model_valid = 1'b0;
    logic [31:0] model_rdata = '0;
    logic        spur_valid = 1'b0;
    logic [31:0] spur_rdata = '0;

    assign bram_valid = model_valid | spur_valid;
    assign ram_rdata  = model_valid ? model_rdata : spur_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } ramx_t;

    resp_t resp_q[$];
    ramx_t ram_q[$];

    logic [31:0] bram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    logic        res_valid [16];
    logic        res_dirty [16];
    logic [31:0] res_addr  [16];

    cache_mem_ctrl dut (
        .cpu_clk         (cpu_clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_ready       (cpu_ready),
        .cache_ram_valid (cache_ram_valid),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .bram_valid      (bram_valid),
        .ram_rdata       (ram_rdata)
    );

    initial forever #5 cpu_clk = ~cpu_clk;
    initial forever begin
        @(posedge cpu_clk);
        cyc = cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors = vectors + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [31:0] init_val(logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0080) return 32'h0000_0000;
        return {a[15:0] ^ a[31:16], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] bram_rd(logic [31:0] a);
        return bram_mem.exists(a) ? bram_mem[a] : init_val(a);
    endfunction

    // BRAM latency model: completion 9 cycles after the request cycle.
    initial begin : bram_model
        logic        we_l;
        logic [31:0] a_l;
        logic [31:0] d_l;
        forever begin
            @(negedge cpu_clk);
            if (cache_ram_valid && !rst) begin
                we_l = ram_we;
                a_l  = ram_addr;
                d_l  = ram_wdata;
                repeat (9) @(posedge cpu_clk);
                #1;
                if (we_l) bram_mem[a_l] = d_l;
                else      model_rdata = bram_rd(a_l);
                model_valid = 1'b1;
                @(posedge cpu_clk);
                #1;
                model_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response or request.
    initial begin : monitor
        logic  prev_crv;
        logic  outstanding;
        resp_t r;
        ramx_t x;
        prev_crv    = 1'b0;
        outstanding = 1'b0;
        forever begin
            @(negedge cpu_clk);
            if (rst) begin
                prev_crv    = 1'b0;
                outstanding = 1'b0;
            end else begin
                if (cpu_ready) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_ready", 32'(cpu_ready), 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("ready_cycle", 32'(cyc), 32'(r.due));
                        if (r.is_load) check("load_data", cpu_rdata, r.rdata);
                    end
                end
                if (cache_ram_valid) begin
                    check("ram_valid_back_to_back", 32'(prev_crv), 32'd0);
                    check("ram_valid_outstanding", 32'(outstanding), 32'd0);
                    if (ram_q.size() == 0) begin
                        check("unexpected_ram_req", 32'(cache_ram_valid), 32'd0);
                    end else begin
                        x = ram_q.pop_front();
                        check("ram_req_cycle", 32'(cyc), 32'(x.due));
                        check("ram_we", 32'(ram_we), 32'(x.we));
                        check("ram_addr", ram_addr, x.addr);
                        if (x.we) check("ram_wdata", ram_wdata, x.wdata);
                    end
                end
                if (bram_valid) outstanding = 1'b0;
                if (cache_ram_valid) outstanding = 1'b1;
                prev_crv = cache_ram_valid;
            end
        end
    end

    // Issue one request, push its expected response and BRAM traffic, wait for ready.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] w;
        int          idx;
        int          t;
        int          n;
        resp_t       r;
        ramx_t       x;
        w   = {addr[31:2], 2'b00};
        idx = int'(w[5:2]);
        @(negedge cpu_clk);
        t = cyc;
        if (res_valid[idx] && res_addr[idx] == w) begin
            r.due = t + 1;
        end else begin
            if (res_valid[idx] && res_dirty[idx]) begin
                x = '{1'b1, res_addr[idx], ref_rd(res_addr[idx]), t + 1};
                ram_q.push_back(x);
                x = '{1'b0, w, 32'h0, t + 11};
                ram_q.push_back(x);
                r.due = t + 21;
            end else begin
                x = '{1'b0, w, 32'h0, t + 1};
                ram_q.push_back(x);
                r.due = t + 11;
            end
            res_valid[idx] = 1'b1;
            res_addr[idx]  = w;
            res_dirty[idx] = 1'b0;
        end
        r.is_load = !we;
        r.rdata   = ref_rd(w);
        if (we) begin
            ref_mem[w]     = wdata;
            res_dirty[idx] = 1'b1;
        end
        resp_q.push_back(r);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        n = 0;
        do begin
            @(negedge cpu_clk);
            n = n + 1;
        end while (!cpu_ready && n < 60);
        if (!cpu_ready) begin
            check("ready_timeout", 32'(cpu_ready), 32'd1);
            resp_q.delete();
            ram_q.delete();
        end
        cpu_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, "_ram_valid"}, 32'(cache_ram_valid), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_addr"}, ram_addr, 32'd0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    endtask

    task automatic spurious_bram(input logic [31:0] held_rdata);
        @(posedge cpu_clk);
        #1;
        spur_rdata = $urandom;
        spur_valid = 1'b1;
        @(posedge cpu_clk);
        #1;
        spur_valid = 1'b0;
        @(negedge cpu_clk);
        check("spurious_state", 32'(dut.state), 32'(IDLE));
        check("spurious_ram_valid", 32'(cache_ram_valid), 32'd0);
        check("spurious_rdata_held", cpu_rdata, held_rdata);
    endtask

    initial begin : stimulus
        int          t;
        ramx_t       x;
        logic [31:0] a;
        logic [31:0] last_rdata;
        for (int i = 0; i < 16; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_addr[i]  = '0;
        end

        repeat (3) @(negedge cpu_clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed scenarios: clean miss, hit, store hit, dirty eviction, store miss.
        do_req(1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b0, 32'h0000_0040, 32'h0);
        do_req(1'b1, 32'h0000_0040, 32'h1234_5678);
        do_req(1'b0, 32'h0000_0440, 32'h0);
        do_req(1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        do_req(1'b0, 32'h0000_0080, 32'h0);

        spurious_bram(32'hA5A5_A5A5);
        do_req(1'b0, 32'h0000_0080, 32'h0);

        // Reset in the middle of a clean miss to index 1.
        @(negedge cpu_clk);
        t = cyc;
        x = '{1'b0, 32'h0000_0044, 32'h0, t + 1};
        ram_q.push_back(x);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0044;
        repeat (5) @(posedge cpu_clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midmiss_reset");
        cpu_req = 1'b0;
        repeat (2) @(negedge cpu_clk);
        check("midmiss_ram_q_drained", 32'(ram_q.size()), 32'd0);
        resp_q.delete();
        ram_q.delete();
        for (int i = 0; i < 16; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
        end
        ref_mem = bram_mem;
        rst = 1'b0;
        repeat (15) @(negedge cpu_clk);

        do_req(1'b0, 32'h0000_0080, 32'h0);
        do_req(1'b0, 32'h0000_0040, 32'h0);

        // Randomized traffic over 4 tags x 16 lines plus a far tag region.
        last_rdata = ref_rd(32'h0000_0040);
        for (int i = 0; i < 250; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap == 3) spurious_bram(last_rdata);
            else repeat (gap) @(negedge cpu_clk);
            a = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'hABCD_0000;
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_req(1'b1, a, $urandom);
            end else begin
                last_rdata = ref_rd({a[31:2], 2'b00});
                do_req(1'b0, a, 32'h0);
            end
        end

        repeat (3) @(negedge cpu_clk);
        check("final_resp_q_empty", 32'(resp_q.size()), 32'd0);
        check("final_ram_q_empty", 32'(ram_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
